udp_order_parser: RTL and testbench

- Upstream ingress stage of trading_system_top, in the clk_udp domain.
- Consumes the byte-wide UDP RX AXI-Stream and filters frames on ethertype, IP protocol, destination IP and UDP source port.
- Decodes the 3-byte opcode and emits big-endian 32-bit orders {price[31:16], is_buy[15], is_bot[14], qty[13:0]} to the input CDC FIFO.
- Pulses a dump request for book-dump frames; keeps saturating health counters.

---
 rtl/hft_pkg.sv | 58 +++++
 rtl/udp_order_parser_if.sv | 23 ++
 rtl/sat_counter.sv | 20 ++
 rtl/udp_order_parser.sv | 168 ++++++++++++++++
 tb/tb_udp_order_parser.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hft_pkg.sv
// Shared types and frame layout for the UDP order ingress path.
// Holds the order word format, parser states, byte offsets and the header filter helper.
package hft_pkg;

   typedef struct packed {
      logic [15:0] price;
      logic        is_buy;
      logic        is_bot;
      logic [13:0] qty;
   } order_t;

   typedef enum logic [2:0] {
      HDR,
      OPC,
      PAY,
      DUMPW,
      DROP
   } state_t;

   localparam int OFF_ETYPE = 12;
   localparam int OFF_PROTO = 23;
   localparam int OFF_DIP   = 30;
   localparam int OFF_SPORT = 34;
   localparam int OFF_OPC   = 42;
   localparam int OFF_PAY   = 45;

   localparam logic [7:0]  ETYPE_HI  = 8'h08;
   localparam logic [7:0]  ETYPE_LO  = 8'h00;
   localparam logic [7:0]  PROTO_UDP = 8'h11;

   localparam logic [31:0] DEF_DEST_IP   = 32'hC0A80132;
   localparam logic [15:0] DEF_SRC_PORT  = 16'd55555;
   localparam logic [23:0] DEF_OP_MARKET = 24'h102030;
   localparam logic [23:0] DEF_OP_DUMP   = 24'hF0E0D0;

   // Bytes at offsets not listed here are don't-care and always pass.
   function automatic logic hdr_byte_ok(input logic [5:0]  idx,
                                        input logic [7:0]  data,
                                        input logic [31:0] dest_ip,
                                        input logic [15:0] src_port);
      logic ok;
      ok = 1'b1;
      case (idx)
         6'(OFF_ETYPE):     ok = (data == ETYPE_HI);
         6'(OFF_ETYPE + 1): ok = (data == ETYPE_LO);
         6'(OFF_PROTO):     ok = (data == PROTO_UDP);
         6'(OFF_DIP):       ok = (data == dest_ip[31:24]);
         6'(OFF_DIP + 1):   ok = (data == dest_ip[23:16]);
         6'(OFF_DIP + 2):   ok = (data == dest_ip[15:8]);
         6'(OFF_DIP + 3):   ok = (data == dest_ip[7:0]);
         6'(OFF_SPORT):     ok = (data == src_port[15:8]);
         6'(OFF_SPORT + 1): ok = (data == src_port[7:0]);
         default:           ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/udp_order_parser_if.sv
// Stream bundle between the UDP RX MAC, the order parser and the input CDC FIFO.
// The RX side has no backpressure; only the order side carries a ready.
interface udp_order_parser_if;
   import hft_pkg::*;

   logic [7:0] rx_axis_tdata;
   logic       rx_axis_tvalid;
   logic       rx_axis_tlast;
   order_t     order_tdata;
   logic       order_tvalid;
   logic       order_tready;

   modport master (
      output rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, order_tready,
      input  order_tdata, order_tvalid
   );

   modport slave (
      input  rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, order_tready,
      output order_tdata, order_tvalid
   );

endinterface

// File: rtl/sat_counter.sv
// Health counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/udp_order_parser.sv
// UDP ingress: filters frames on L2/L3/L4 header fields, decodes the opcode,
// emits 32-bit orders with a one-deep holding register and keeps health counters.
module udp_order_parser
   import hft_pkg::*;
#(
   parameter logic [31:0] DEST_IP   = DEF_DEST_IP,
   parameter logic [15:0] SRC_PORT  = DEF_SRC_PORT,
   parameter logic [23:0] OP_MARKET = DEF_OP_MARKET,
   parameter logic [23:0] OP_DUMP   = DEF_OP_DUMP,
   parameter int          CNT_W     = 16
) (
   input  logic                  clk_udp,
   input  logic                  rst_udp,
   udp_order_parser_if.slave     bus,
   output logic                  dump_req,
   output logic [CNT_W-1:0]      frames_ok,
   output logic [CNT_W-1:0]      frames_dropped,
   output logic [CNT_W-1:0]      orders_lost
);

   state_t      state;
   logic [5:0]  bcnt;
   logic [1:0]  lane;
   logic [15:0] opc_sr;
   logic [23:0] word_sr;

   logic        beat;
   logic        last_beat;
   logic        hdr_pass;
   logic [23:0] opc_next;
   order_t      word_next;
   logic        word_done;
   logic        load_word;
   logic        ok_inc;
   logic        drop_inc;
   logic        lost_inc;
   logic        dump_hit;

   assign beat      = bus.rx_axis_tvalid;
   assign last_beat = bus.rx_axis_tvalid & bus.rx_axis_tlast;
   assign hdr_pass  = hdr_byte_ok(bcnt, bus.rx_axis_tdata, DEST_IP, SRC_PORT);
   assign opc_next  = {opc_sr, bus.rx_axis_tdata};
   assign word_next = order_t'({word_sr, bus.rx_axis_tdata});

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      word_done = 1'b0;
      ok_inc    = 1'b0;
      drop_inc  = 1'b0;
      lost_inc  = 1'b0;
      dump_hit  = 1'b0;
      if (beat) begin
         case (state)
            HDR: drop_inc = bus.rx_axis_tlast;
            OPC: begin
               // A dump frame may legally end on its last opcode byte.
               if (bus.rx_axis_tlast) begin
                  if ((bcnt == 6'(OFF_PAY - 1)) && (opc_next == OP_DUMP)) begin
                     ok_inc   = 1'b1;
                     dump_hit = 1'b1;
                  end else begin
                     drop_inc = 1'b1;
                  end
               end
            end
            PAY: begin
               word_done = (lane == 2'd3);
               if (bus.rx_axis_tlast) begin
                  ok_inc   = 1'b1;
                  lost_inc = (lane != 2'd3);
               end
            end
            DUMPW: begin
               ok_inc   = bus.rx_axis_tlast;
               dump_hit = bus.rx_axis_tlast;
            end
            DROP:    drop_inc = bus.rx_axis_tlast;
            default: ;
         endcase
      end
      // A completed word with the holding register still blocked is lost.
      load_word = word_done & ~(bus.order_tvalid & ~bus.order_tready);
      if (word_done && bus.order_tvalid && !bus.order_tready) begin
         lost_inc = 1'b1;
      end
   end

   always_ff @(posedge clk_udp) begin
      if (rst_udp) begin
         state            <= HDR;
         bcnt             <= '0;
         lane             <= '0;
         opc_sr           <= '0;
         word_sr          <= '0;
         bus.order_tdata  <= '0;
         bus.order_tvalid <= 1'b0;
         dump_req         <= 1'b0;
      end else begin
         dump_req <= dump_hit;

         if (bus.order_tvalid && bus.order_tready) begin
            bus.order_tvalid <= 1'b0;
         end
         if (load_word) begin
            bus.order_tdata  <= word_next;
            bus.order_tvalid <= 1'b1;
         end

         if (last_beat) begin
            state <= HDR;
            bcnt  <= '0;
            lane  <= '0;
         end else if (beat) begin
            case (state)
               HDR: begin
                  bcnt <= bcnt + 6'd1;
                  if (!hdr_pass) begin
                     state <= DROP;
                  end else if (bcnt == 6'(OFF_OPC - 1)) begin
                     state <= OPC;
                  end
               end
               OPC: begin
                  bcnt   <= bcnt + 6'd1;
                  opc_sr <= opc_next[15:0];
                  if (bcnt == 6'(OFF_PAY - 1)) begin
                     if (opc_next == OP_MARKET) begin
                        state <= PAY;
                     end else if (opc_next == OP_DUMP) begin
                        state <= DUMPW;
                     end else begin
                        state <= DROP;
                     end
                  end
               end
               PAY: begin
                  lane    <= lane + 2'd1;
                  word_sr <= {word_sr[15:0], bus.rx_axis_tdata};
               end
               DUMPW, DROP: ;
               default: state <= HDR;
            endcase
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_frames_ok (
      .clk   (clk_udp),
      .rst   (rst_udp),
      .inc   (ok_inc),
      .count (frames_ok)
   );

   sat_counter #(.CNT_W(CNT_W)) u_frames_dropped (
      .clk   (clk_udp),
      .rst   (rst_udp),
      .inc   (drop_inc),
      .count (frames_dropped)
   );

   sat_counter #(.CNT_W(CNT_W)) u_orders_lost (
      .clk   (clk_udp),
      .rst   (rst_udp),
      .inc   (lost_inc),
      .count (orders_lost)
   );

endmodule

// File: tb/tb_udp_order_parser.sv
// Directed bench for udp_order_parser: filter, opcode decode, backpressure loss,
// runt/truncation handling, tvalid gaps and mid-frame reset.
module tb_udp_order_parser;
   import hft_pkg::*;

   localparam logic [31:0] DIP    = 32'hC0A80132;
   localparam logic [15:0] SPORT  = 16'd55555;
   localparam logic [23:0] OP_MKT = 24'h102030;
   localparam logic [23:0] OP_DMP = 24'hF0E0D0;

   logic        clk_udp = 1'b0;
   logic        rst_udp = 1'b1;
   logic        dump_req;
   logic [15:0] frames_ok;
   logic [15:0] frames_dropped;
   logic [15:0] orders_lost;

   logic [7:0]  frm[$];
   logic [31:0] got[$];
   int          dump_cnt = 0;
   int          n_checks = 0;
   int          n_err    = 0;

   logic [31:0] exp6 [6] = '{32'h00608013, 32'h00618027, 32'h0060800B,
                             32'h00628016, 32'h00680027, 32'h0068000B};

   always #4 clk_udp = ~clk_udp;

   udp_order_parser_if bus ();

   udp_order_parser dut (
      .clk_udp        (clk_udp),
      .rst_udp        (rst_udp),
      .bus            (bus),
      .dump_req       (dump_req),
      .frames_ok      (frames_ok),
      .frames_dropped (frames_dropped),
      .orders_lost    (orders_lost)
   );

   // Inputs change 2 ns after posedge, so negedge sees the values the next edge will use.
   always @(negedge clk_udp) begin
      if (bus.order_tvalid && bus.order_tready) got.push_back(bus.order_tdata);
      if (dump_req) dump_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_udp);
         #2;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      bus.rx_axis_tdata  = d;
      bus.rx_axis_tvalid = 1'b1;
      bus.rx_axis_tlast  = last;
      @(posedge clk_udp);
      #2;
      bus.rx_axis_tvalid = 1'b0;
      bus.rx_axis_tlast  = 1'b0;
   endtask

   task automatic start_frame(input logic [31:0] dip, input logic [15:0] sport,
                              input logic [23:0] opc);
      frm.delete();
      for (int i = 0; i < 42; i++) frm.push_back(8'(i + 8'h40));
      frm[12] = 8'h08;
      frm[13] = 8'h00;
      frm[23] = 8'h11;
      frm[30] = dip[31:24];
      frm[31] = dip[23:16];
      frm[32] = dip[15:8];
      frm[33] = dip[7:0];
      frm[34] = sport[15:8];
      frm[35] = sport[7:0];
      frm.push_back(opc[23:16]);
      frm.push_back(opc[15:8]);
      frm.push_back(opc[7:0]);
   endtask

   task automatic add_order(input logic [15:0] price, input logic buy, input logic [13:0] qty);
      frm.push_back(price[15:8]);
      frm.push_back(price[7:0]);
      frm.push_back({buy, 1'b0, qty[13:8]});
      frm.push_back(qty[7:0]);
   endtask

   task automatic build_market6();
      start_frame(DIP, SPORT, OP_MKT);
      add_order(16'd96,  1'b1, 14'd19);
      add_order(16'd97,  1'b1, 14'd39);
      add_order(16'd96,  1'b1, 14'd11);
      add_order(16'd98,  1'b1, 14'd22);
      add_order(16'd104, 1'b0, 14'd39);
      add_order(16'd104, 1'b0, 14'd11);
   endtask

   task automatic send_frame();
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i], i == frm.size() - 1);
   endtask

   task automatic check_got6(input string tag);
      check({tag, "_count"}, 32'(got.size()), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("%s_w%0d", tag, i), got[i], exp6[i]);
   endtask

   initial begin
      bus.rx_axis_tdata  = 8'h00;
      bus.rx_axis_tvalid = 1'b0;
      bus.rx_axis_tlast  = 1'b0;
      bus.order_tready   = 1'b1;
      idle(3);

      // Reset values
      check("rst_tvalid",  32'(bus.order_tvalid), 32'd0);
      check("rst_tdata",   bus.order_tdata,       32'd0);
      check("rst_dump",    32'(dump_req),         32'd0);
      check("rst_ok",      32'(frames_ok),        32'd0);
      check("rst_dropped", 32'(frames_dropped),   32'd0);
      check("rst_lost",    32'(orders_lost),      32'd0);
      rst_udp = 1'b0;
      idle(2);

      // Six-order MARKET frame, ready held high
      got.delete();
      build_market6();
      send_frame();
      idle(3);
      check_got6("mkt6");
      check("mkt6_ok",   32'(frames_ok),   32'd1);
      check("mkt6_lost", 32'(orders_lost), 32'd0);

      // DUMP frame with one padding byte, then one ending exactly on byte 44
      got.delete();
      dump_cnt = 0;
      start_frame(DIP, SPORT, OP_DMP);
      frm.push_back(8'hAA);
      send_frame();
      check("dump_pulse_hi", 32'(dump_req), 32'd1);
      idle(1);
      check("dump_pulse_lo", 32'(dump_req), 32'd0);
      start_frame(DIP, SPORT, OP_DMP);
      send_frame();
      check("dump44_pulse", 32'(dump_req), 32'd1);
      idle(3);
      check("dump_cnt",    32'(dump_cnt),    32'd2);
      check("dump_orders", 32'(got.size()),  32'd0);
      check("dump_ok",     32'(frames_ok),   32'd3);

      // Filtered frames: wrong IP, wrong source port, unknown opcode
      start_frame(32'hC0A80151, SPORT, OP_MKT);
      add_order(16'd96, 1'b1, 14'd19);
      send_frame();
      start_frame(DIP, 16'd1234, OP_MKT);
      add_order(16'd96, 1'b1, 14'd19);
      send_frame();
      start_frame(DIP, SPORT, 24'h000000);
      add_order(16'd96, 1'b1, 14'd19);
      send_frame();
      idle(3);
      check("filt_orders",  32'(got.size()),      32'd0);
      check("filt_dump",    32'(dump_cnt),        32'd2);
      check("filt_dropped", 32'(frames_dropped),  32'd3);
      check("filt_ok",      32'(frames_ok),       32'd3);

      // Backpressure: five orders against a stalled FIFO
      bus.order_tready = 1'b0;
      build_market6();
      frm = frm[0:64];
      send_frame();
      idle(1);
      check("bp_tvalid",  32'(bus.order_tvalid), 32'd1);
      check("bp_tdata",   bus.order_tdata,       32'h00608013);
      check("bp_lost",    32'(orders_lost),      32'd4);
      idle(5);
      check("bp_hold",    bus.order_tdata,       32'h00608013);
      check("bp_none",    32'(got.size()),       32'd0);
      bus.order_tready = 1'b1;
      idle(2);
      start_frame(DIP, SPORT, OP_MKT);
      add_order(16'd104, 1'b0, 14'd39);
      add_order(16'd104, 1'b0, 14'd11);
      send_frame();
      idle(3);
      check("bp_count", 32'(got.size()), 32'd3);
      check("bp_w0",    got[0],           32'h00608013);
      check("bp_w1",    got[1],           32'h00680027);
      check("bp_w2",    got[2],           32'h0068000B);
      check("bp_ok",    32'(frames_ok),   32'd5);

      // Runt frame, then a MARKET frame with a 6-byte payload
      got.delete();
      start_frame(DIP, SPORT, OP_MKT);
      frm = frm[0:20];
      send_frame();
      idle(2);
      check("runt_dropped", 32'(frames_dropped), 32'd4);
      start_frame(DIP, SPORT, OP_MKT);
      add_order(16'd96, 1'b1, 14'd19);
      frm.push_back(8'h00);
      frm.push_back(8'h61);
      send_frame();
      idle(3);
      check("trunc_count", 32'(got.size()),   32'd1);
      check("trunc_w0",    got[0],            32'h00608013);
      check("trunc_lost",  32'(orders_lost),  32'd5);
      check("trunc_ok",    32'(frames_ok),    32'd6);

      // Same six-order frame with 3 idle cycles between bytes
      got.delete();
      build_market6();
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i], i == frm.size() - 1);
         if (i == 47) check("gap_lat_pre",  32'(bus.order_tvalid), 32'd0);
         if (i == 48) begin
            check("gap_lat_vld", 32'(bus.order_tvalid), 32'd1);
            check("gap_lat_dat", bus.order_tdata,       32'h00608013);
         end
         if (i != frm.size() - 1) idle(3);
      end
      idle(3);
      check_got6("gap");
      check("gap_ok", 32'(frames_ok), 32'd7);

      // Reset asserted on byte 47 of a MARKET frame
      got.delete();
      start_frame(DIP, SPORT, OP_MKT);
      add_order(16'd96, 1'b1, 14'd19);
      add_order(16'd97, 1'b1, 14'd39);
      for (int i = 0; i < 47; i++) send_byte(frm[i], 1'b0);
      rst_udp = 1'b1;
      send_byte(frm[47], 1'b0);
      idle(1);
      check("mrst_tvalid",  32'(bus.order_tvalid), 32'd0);
      check("mrst_ok",      32'(frames_ok),        32'd0);
      check("mrst_dropped", 32'(frames_dropped),   32'd0);
      check("mrst_lost",    32'(orders_lost),      32'd0);
      rst_udp = 1'b0;
      for (int i = 48; i < frm.size(); i++) send_byte(frm[i], i == frm.size() - 1);
      idle(2);
      check("mrst_rem_dropped", 32'(frames_dropped), 32'd1);
      check("mrst_rem_ok",      32'(frames_ok),      32'd0);
      check("mrst_rem_orders",  32'(got.size()),     32'd0);
      build_market6();
      send_frame();
      idle(3);
      check_got6("mrst_clean");
      check("mrst_clean_ok",   32'(frames_ok),   32'd1);
      check("mrst_clean_lost", 32'(orders_lost), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
